// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding, default constants and clog2 shared by the word UART transmitter
package uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
  localparam int CLKS_PER_BIT_DEF = 434;
  localparam logic [7:0] DELIM_DEF = 8'h0A;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) r = ((1 << i) < n) ? i + 1 : r;
    return r;
  endfunction
endpackage

// File: rtl/word_fifo.sv
// word_fifo: sync FIFO (clk, active-low async rst, i_push/i_pop/i_data in; o_data registered on pop, o_empty/o_full/o_count out)
module word_fifo
  import uart_pkg::*;
#(
  parameter int W = 32,
  parameter int DEPTH = 4,
  localparam int AW = clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_data,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_count
);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic w_pop, w_push;
  logic [AW:0] w_count;
  assign w_pop = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);
  assign w_count = o_count + CW'(w_push) - CW'(w_pop);
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wr <= '0;
      r_rd <= '0;
      o_count <= '0;
      o_empty <= 1'b1;
      o_full <= 1'b0;
      o_data <= '0;
    end else begin
      r_wr <= r_wr + AW'(w_push);
      r_rd <= r_rd + AW'(w_pop);
      o_count <= w_count;
      o_empty <= w_count == '0;
      o_full <= w_count == CW'(DEPTH);
      if (w_pop) o_data <= r_mem[r_rd];
    end
endmodule

// File: rtl/uart_word_tx.sv
// uart_word_tx: buffers 32-bit words and sends each as 4 MSB-first 8N1 bytes plus optional delimiter (clk, rst, data_in, i_wr_uart -> tx, o_busy, o_fifo_full, o_overflow)
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int DELIM_EN = 1,
  parameter logic [7:0] DELIM_BYTE = DELIM_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        i_wr_uart,
  output logic        tx,
  output logic        o_busy,
  output logic        o_fifo_full,
  output logic        o_overflow
);
  localparam int AW = clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0] NBYTES = (DELIM_EN != 0) ? 3'd5 : 3'd4;
  localparam logic [7:0] TAIL = (DELIM_EN != 0) ? DELIM_BYTE : 8'h00;
  state_t r_state;
  logic [15:0] r_baud;
  logic [2:0] r_bit, r_bytes;
  logic [39:0] r_shift;
  logic r_load, r_tx, r_busy, r_overflow;
  logic w_pop, w_tick, w_empty, w_full;
  logic [2:0] w_nbit;
  logic [7:0] w_byte;
  logic [31:0] w_rd_data;
  logic [AW:0] w_count;
  assign w_pop = (r_state == IDLE) & ~w_empty;
  assign w_tick = r_baud == BAUD_MAX;
  assign w_nbit = r_bit + 3'd1;
  assign w_byte = r_shift[39:32];
  assign tx = r_tx;
  assign o_busy = r_busy;
  assign o_fifo_full = w_full;
  assign o_overflow = r_overflow;
  word_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (i_wr_uart),
    .i_pop   (w_pop),
    .i_data  (data_in),
    .o_data  (w_rd_data),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_busy <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_busy <= (r_state != IDLE) | (w_count != '0);
      r_overflow <= i_wr_uart & w_full & ~w_pop;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_baud <= '0;
      r_bit <= '0;
      r_bytes <= '0;
      r_shift <= '0;
      r_load <= 1'b0;
      r_tx <= 1'b1;
    end else begin
      r_load <= w_pop;
      r_baud <= w_tick ? '0 : r_baud + 16'd1;
      if (r_load) r_shift <= {w_rd_data, TAIL};
      case (r_state)
        IDLE: begin
          r_baud <= '0;
          r_bytes <= NBYTES;
          if (w_pop) begin
            r_state <= START;
            r_tx <= 1'b0;
          end
        end
        START: if (w_tick) begin
          r_state <= DATA;
          r_bit <= '0;
          r_tx <= w_byte[0];
        end
        DATA: if (w_tick) begin
          r_bit <= w_nbit;
          r_state <= (r_bit == 3'd7) ? STOP : DATA;
          r_tx <= (r_bit == 3'd7) | w_byte[w_nbit];
        end
        STOP: if (w_tick) begin
          r_bytes <= r_bytes - 3'd1;
          if (r_bytes != 3'd1) begin
            r_state <= START;
            r_tx <= 1'b0;
            r_shift <= r_shift << 8;
          end else r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: scoreboard bench decoding both UART lines against queued expected bytes
module tb_uart_word_tx;
  typedef struct {logic [7:0] b; int gap;} exp_t;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] d_a = '0, d_b = '0;
  logic wr_a = 1'b0, wr_b = 1'b0;
  logic tx_a, busy_a, full_a, ovf_a, tx_b, busy_b, full_b, ovf_b;
  exp_t exp_a[$], exp_b[$];
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  uart_word_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .DELIM_EN(1), .DELIM_BYTE(8'h0A)) u_a (
    .clk(clk), .rst(rst), .data_in(d_a), .i_wr_uart(wr_a),
    .tx(tx_a), .o_busy(busy_a), .o_fifo_full(full_a), .o_overflow(ovf_a)
  );
  uart_word_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .DELIM_EN(0), .DELIM_BYTE(8'h0A)) u_b (
    .clk(clk), .rst(rst), .data_in(d_b), .i_wr_uart(wr_b),
    .tx(tx_b), .o_busy(busy_b), .o_fifo_full(full_b), .o_overflow(ovf_b)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask
  function automatic logic line(input bit s);
    return s ? tx_b : tx_a;
  endfunction
  task automatic rx_frame(input bit s, output logic [9:0] f, output int gap, output int bad, output bit ok);
    f = '0;
    gap = 0;
    bad = 0;
    ok = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) return;
      if (line(s) === 1'b0) break;
      gap++;
    end
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < 4; j++) begin
        if (k != 0 || j != 0) begin
          @(negedge clk);
          if (!rst) return;
        end
        if (j == 0) f[k] = line(s);
        else if (line(s) !== f[k]) bad++;
      end
    ok = 1'b1;
  endtask
  task automatic monitor(input bit s);
    logic [9:0] f;
    int gap, bad, left;
    bit ok;
    exp_t e;
    string p;
    if (s) p = "b";
    else p = "a";
    forever begin
      rx_frame(s, f, gap, bad, ok);
      left = s ? exp_b.size() : exp_a.size();
      if (!ok) wait (rst);
      else if (left == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL %s_extra: got byte %02h, want none", p, f[8:1]);
      end else begin
        if (s) e = exp_b.pop_front();
        else e = exp_a.pop_front();
        chk({p, "_frame"}, {22'd0, f}, {22'd0, 1'b1, e.b, 1'b0});
        chk({p, "_bitlen"}, bad, 0);
        if (e.gap >= 0) begin
          n_vec++;
          if (gap > e.gap) begin
            n_err++;
            $display("FAIL %s_gap: got %0d idle clks, want at most %0d", p, gap, e.gap);
          end
        end
      end
    end
  endtask
  task automatic push_word(input bit s, input logic [31:0] w, input int g);
    exp_t e;
    for (int i = 0; i < 5; i++)
      if (i < 4 || !s) begin
        e.b = (i < 4) ? w[31 - 8 * i -: 8] : 8'h0A;
        e.gap = (i == 0) ? g : 0;
        if (s) exp_b.push_back(e);
        else exp_a.push_back(e);
      end
  endtask
  task automatic strobe(input bit s, input logic [31:0] w);
    if (s) begin
      d_b = w;
      wr_b = 1'b1;
    end else begin
      d_a = w;
      wr_a = 1'b1;
    end
  endtask
  task automatic idle_wr();
    wr_a = 1'b0;
    wr_b = 1'b0;
    d_a = ~d_a;
    d_b = ~d_b;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || busy_a || busy_b) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 6000) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d clks, want under 6000", n);
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic timed_word(input bit s, input logic [31:0] w, input int clks);
    int n;
    n = 1;
    strobe(s, w);
    push_word(s, w, -1);
    @(negedge clk);
    idle_wr();
    chk("lat_idle_tx", s ? tx_b : tx_a, 1);
    chk("lat_idle_busy", s ? busy_b : busy_a, 0);
    @(negedge clk);
    chk("lat_start_tx", s ? tx_b : tx_a, 0);
    chk("lat_busy", s ? busy_b : busy_a, 1);
    repeat (1000) begin
      @(negedge clk);
      if (!(s ? busy_b : busy_a)) break;
      n++;
    end
    chk("busy_len", n, clks + 1);
  endtask
  initial monitor(1'b0);
  initial monitor(1'b1);
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] w;
    repeat (2) @(negedge clk);
    chk("rst_tx_a", tx_a, 1);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_full_a", full_a, 0);
    chk("rst_ovf_a", ovf_a, 0);
    chk("rst_tx_b", tx_b, 1);
    chk("rst_busy_b", busy_b, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    timed_word(1'b0, 32'hDEADBEEF, 200);
    drain();
    timed_word(1'b1, 32'h01020304, 160);
    drain();
    for (int i = 0; i < 6; i++) begin
      w = 32'h10203040 + 32'h01010101 * i;
      strobe(1'b0, w);
      if (i < 5) push_word(1'b0, w, (i == 0) ? -1 : 1);
      @(negedge clk);
      if (i < 5) chk("ovf_early", ovf_a, 0);
      if (i == 3) chk("full_early", full_a, 0);
      if (i == 4) chk("full_at_depth", full_a, 1);
    end
    idle_wr();
    chk("ovf_pulse", ovf_a, 1);
    chk("ovf_full", full_a, 1);
    @(negedge clk);
    chk("ovf_one_cycle", ovf_a, 0);
    drain();
    strobe(1'b0, 32'hC0C0C0C0);
    push_word(1'b0, 32'hC0C0C0C0, -1);
    @(negedge clk);
    for (int i = 1; i < 5; i++) begin
      w = 32'hC0C0C0C0 + 32'h01010101 * i;
      strobe(1'b0, w);
      push_word(1'b0, w, 1);
      @(negedge clk);
    end
    idle_wr();
    chk("fp_full", full_a, 1);
    repeat (197) @(negedge clk);
    strobe(1'b0, 32'h5A5A5A5A);
    push_word(1'b0, 32'h5A5A5A5A, 1);
    @(negedge clk);
    idle_wr();
    chk("fp_ovf", ovf_a, 0);
    chk("fp_full_kept", full_a, 1);
    @(negedge clk);
    chk("fp_ovf_next", ovf_a, 0);
    drain();
    strobe(1'b0, 32'h12345678);
    push_word(1'b0, 32'h12000000, -1);
    void'(exp_a.pop_back());
    void'(exp_a.pop_back());
    void'(exp_a.pop_back());
    void'(exp_a.pop_back());
    @(negedge clk);
    strobe(1'b0, 32'h9ABCDEF0);
    @(negedge clk);
    idle_wr();
    repeat (57) @(negedge clk);
    chk("pre_rst_tx", tx_a, 0);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_tx", tx_a, 1);
    chk("async_rst_busy", busy_a, 0);
    chk("async_rst_full", full_a, 0);
    exp_a.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", busy_a, 0);
    chk("post_rst_tx", tx_a, 1);
    strobe(1'b0, 32'hA5A5A5A5);
    push_word(1'b0, 32'hA5A5A5A5, -1);
    @(negedge clk);
    idle_wr();
    drain();
    strobe(1'b0, 32'h11111111);
    push_word(1'b0, 32'h11111111, -1);
    @(negedge clk);
    idle_wr();
    repeat (30) @(negedge clk);
    strobe(1'b0, 32'h22222222);
    push_word(1'b0, 32'h22222222, 1);
    @(negedge clk);
    idle_wr();
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
